traffic_phase_arbiter: RTL and testbench

Demand-actuated phase scheduler for a four-approach intersection. It latches vehicle requests from the NS, EW, SN and WE approaches and grants the green phase to one approach at a time in round-robin order. Every green is followed by a yellow interval and then an all-red clearance interval. It replaces the fixed-cycle sequencer wherever approach detectors exist, and drives the same per-approach 2-bit light outputs.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/traffic_phase_arbiter_rr_pick4.sv | 25 ++
 rtl/traffic_phase_arbiter.sv | 111 +++++++++++
 tb/tb_traffic_phase_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase arbiter.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  localparam logic [1:0] NS = 2'd0;
  localparam logic [1:0] EW = 2'd1;
  localparam logic [1:0] SN = 2'd2;
  localparam logic [1:0] WE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } phase_e;

endpackage

// File: rtl/traffic_phase_arbiter_rr_pick4.sv
// Four-way round-robin picker: first set bit in order cur+1, cur+2, cur+3, cur.
module rr_pick4 (
  input  logic [3:0] pending_i,
  input  logic [1:0] cur_i,
  output logic       valid_o,
  output logic [1:0] sel_o
);

  logic [1:0] idx;

  // Walk from the farthest offset down so the nearest candidate wins.
  always_comb begin
    valid_o = 1'b0;
    sel_o   = cur_i;
    idx     = cur_i;
    for (int i = 4; i >= 1; i--) begin
      idx = cur_i + 2'(i);
      if (pending_i[idx]) begin
        valid_o = 1'b1;
        sel_o   = idx;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Demand-actuated round-robin green scheduler with yellow and all-red clearance.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int TW          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  output logic [1:0] ns_light_o,
  output logic [1:0] ew_light_o,
  output logic [1:0] sn_light_o,
  output logic [1:0] we_light_o,
  output logic [3:0] grant_o,
  output logic [3:0] pending_o,
  output logic       busy_o
);

  phase_e          state_q;
  logic [1:0]      cur_q;
  logic [TW-1:0]   cnt_q;
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      cur_onehot, clr, other, pick_src;
  logic            pick_valid;
  logic [1:0]      pick_sel;
  logic [1:0]      light [4];

  assign cur_onehot = 4'b0001 << cur_q;
  assign clr        = (state_q == GREEN) ? cur_onehot : 4'b0000;
  assign pend_d     = (pend_q | req_i) & ~clr;
  assign other      = pend_q & ~cur_onehot;
  // Requests sampled on the all-red exit edge still compete for the next green.
  assign pick_src   = (state_q == ALLRED) ? (pend_q | req_i) : pend_q;

  rr_pick4 u_pick (
    .pending_i (pick_src),
    .cur_i     (cur_q),
    .valid_o   (pick_valid),
    .sel_o     (pick_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= WE;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= GREEN;
            cur_q   <= pick_sel;
            cnt_q   <= '0;
          end
        end
        GREEN: begin
          if ((other != 4'b0000) &&
              ((cnt_q >= TW'(GREEN_MIN - 1)) || (cnt_q >= TW'(GREEN_MAX - 1)))) begin
            state_q <= YELLOW;
            cnt_q   <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        YELLOW: begin
          if (cnt_q == TW'(YELLOW_TIME - 1)) begin
            state_q <= ALLRED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ALLRED: begin
          if (cnt_q == TW'(ALLRED_TIME - 1)) begin
            cnt_q <= '0;
            if (pick_valid) begin
              state_q <= GREEN;
              cur_q   <= pick_sel;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) light[i] = LIGHT_RED;
    if (state_q == GREEN)  light[cur_q] = LIGHT_GREEN;
    if (state_q == YELLOW) light[cur_q] = LIGHT_YELLOW;
  end

  assign ns_light_o = light[NS];
  assign ew_light_o = light[EW];
  assign sn_light_o = light[SN];
  assign we_light_o = light[WE];
  assign grant_o    = ((state_q == GREEN) || (state_q == YELLOW)) ? cur_onehot : 4'b0000;
  assign pending_o  = pend_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Randomized and directed checks of traffic_phase_arbiter against a phase-level model.
module tb_traffic_phase_arbiter;

  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 3;
  localparam int AT   = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] nsL, ewL, snL, weL;
  logic [3:0] grant, pending;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 green, 2 yellow, 3 all-red.
  int       mPhase, mCur, mElapsed, mLeft;
  bit [3:0] mPend;

  traffic_phase_arbiter #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YT), .ALLRED_TIME(AT), .TW(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req),
    .ns_light_o(nsL), .ew_light_o(ewL), .sn_light_o(snL), .we_light_o(weL),
    .grant_o(grant), .pending_o(pending), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic int pickNext(bit [3:0] p, int cur);
    for (int off = 1; off <= 4; off++) begin
      if (p[(cur + off) % 4]) return (cur + off) % 4;
    end
    return cur;
  endfunction

  function automatic logic [1:0] expLight(int a);
    if (a != mCur) return 2'b00;
    if (mPhase == 1) return 2'b01;
    if (mPhase == 2) return 2'b10;
    return 2'b00;
  endfunction

  task automatic modelReset();
    mPhase = 0; mCur = 3; mPend = 4'b0000; mElapsed = 0; mLeft = 0;
  endtask

  task automatic modelStep(input bit [3:0] r);
    bit [3:0] nextPend;
    bit [3:0] mine;
    mine = 4'(1 << mCur);
    nextPend = (mPend | r) & ~((mPhase == 1) ? mine : 4'b0000);
    case (mPhase)
      0: if (mPend != 0) begin mCur = pickNext(mPend, mCur); mPhase = 1; mElapsed = 0; end
      1: begin
        if (((mPend & ~mine) != 0) && (mElapsed + 1 >= GMIN)) begin
          mPhase = 2; mLeft = YT;
        end else mElapsed++;
      end
      2: begin
        mLeft--;
        if (mLeft == 0) begin mPhase = 3; mLeft = AT; end
      end
      default: begin
        mLeft--;
        if (mLeft == 0) begin
          if ((mPend | r) != 0) begin
            mCur = pickNext(mPend | r, mCur); mPhase = 1; mElapsed = 0;
          end else mPhase = 0;
        end
      end
    endcase
    mPend = nextPend;
  endtask

  task automatic expectLit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] expGrant;
    expGrant = (mPhase == 1 || mPhase == 2) ? 4'(1 << mCur) : 4'b0000;
    expectLit("ns_light", 32'(nsL), 32'(expLight(0)));
    expectLit("ew_light", 32'(ewL), 32'(expLight(1)));
    expectLit("sn_light", 32'(snL), 32'(expLight(2)));
    expectLit("we_light", 32'(weL), 32'(expLight(3)));
    expectLit("grant", 32'(grant), 32'(expGrant));
    expectLit("pending", 32'(pending), 32'(mPend));
    expectLit("busy", 32'(busy), 32'(mPhase != 0));
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    modelStep(r);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int budget;
    modelReset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(4'b0000);
    expectLit("reset_busy", 32'(busy), 32'd0);

    // Single NS request, then contention from EW and SN at the first green cycle.
    applyStimulus(4'b0001);
    applyStimulus(4'b0000);
    expectLit("ns_green_after_2", 32'(nsL), 32'h1);
    expectLit("ns_grant", 32'(grant), 32'h1);
    applyStimulus(4'b0110);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    expectLit("ns_green_4th", 32'(nsL), 32'h1);
    applyStimulus(4'b0000);
    expectLit("ns_yellow", 32'(nsL), 32'h2);
    applyStimulus(4'b0001);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    expectLit("allred_lights", 32'({nsL, ewL, snL, weL}), 32'h0);
    expectLit("allred_busy", 32'(busy), 32'h1);
    applyStimulus(4'b0000);
    expectLit("ew_green", 32'(ewL), 32'h1);
    expectLit("ew_grant", 32'(grant), 32'h2);

    // Ride EW green into yellow, then reset asynchronously mid-yellow.
    budget = 20;
    while (mPhase != 2 && budget > 0) begin
      applyStimulus(4'b0000);
      budget--;
    end
    expectLit("reach_yellow", 32'(budget > 0), 32'd1);
    expectLit("ew_yellow", 32'(ewL), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    expectLit("async_reset_lights", 32'({nsL, ewL, snL, weL}), 32'h0);
    expectLit("async_reset_pending", 32'(pending), 32'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111);
    applyStimulus(4'b0000);
    expectLit("ns_first_after_reset", 32'(grant), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) applyStimulus(4'($urandom));
      else applyStimulus(4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
